// File: rtl/prim_assembler.sv
`timescale 1ns/1ps
// Primitive assembly: buffers decode strobes in an event FIFO and groups vertices into
// points, lines or triangles. Define PA_CULL_DEGENERATE_EN to drop degenerate triangles.
module prim_assembler #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3,
    parameter int unsigned VW         = 32
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
    input  logic          StartPrimitive,
    input  logic [3:0]    PrimitiveType,
    input  logic          Draw,
    input  logic [VW-1:0] Vertex,
    input  logic          EndPrimitive,
    input  logic          PrimReady,
    output logic          PrimValid,
    output logic [1:0]    PrimKind,
    output logic [VW-1:0] V0,
    output logic [VW-1:0] V1,
    output logic [VW-1:0] V2,
    output logic          Overflow,
    output logic          Busy
);

    localparam int unsigned EW = VW + 7;
    localparam logic [FIFO_AW:0] DepthC = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               fifo_empty, fifo_full, push_req, push, pop, overflow_q;

    logic [EW-1:0]      rd_entry;
    logic               e_start, e_end, e_draw;
    logic [3:0]         e_type;
    logic [VW-1:0]      e_vert;

    state_e             state_q, state_d;
    logic               close_q, close_d;
    logic [3:0]         type_q, type_d;
    logic [VW-1:0]      p0_q, p0_d, p1_q, p1_d;
    logic [15:0]        k_q, k_d, k_sat;
    logic               par_q, par_d;
    logic [1:0]         kind_q, kind_d, kind_n;
    logic [VW-1:0]      v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [VW-1:0]      a_v, b_v, c_v;
    logic               open_cur, open_n, emit, is_tri;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == DepthC);
    assign push_req   = StartPrimitive | Draw | EndPrimitive;
    assign pop        = !fifo_empty && !(PrimValid && !PrimReady);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = push_req && (!fifo_full || pop);

    assign rd_entry = mem_q[rd_ptr_q];
    assign e_start  = rd_entry[EW-1];
    assign e_end    = rd_entry[EW-2];
    assign e_draw   = rd_entry[EW-3];
    assign e_type   = rd_entry[EW-4 -: 4];
    assign e_vert   = rd_entry[VW-1:0];

    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= {StartPrimitive, EndPrimitive, Draw, PrimitiveType, Vertex};
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            if (push_req && !push) overflow_q <= 1'b1;
        end
    end

    // While emitting, the primitive stays open unless the emitting entry also closed it.
    assign open_cur = (state_q == StAccum) || (state_q == StEmit && !close_q);

    always_comb begin
        state_d = state_q;
        close_d = close_q;
        type_d  = type_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        k_d     = k_q;
        par_d   = par_q;
        kind_d  = kind_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        k_sat   = '0;
        kind_n  = 2'd0;
        a_v     = '0;
        b_v     = '0;
        c_v     = '0;
        emit    = 1'b0;
        is_tri  = 1'b0;
        open_n  = open_cur;

        if (state_q == StEmit && PrimReady) state_d = close_q ? StIdle : StAccum;

        if (pop) begin
            open_n = open_cur || e_start;
            if (e_start) begin
                type_d = e_type;
                k_d    = '0;
                par_d  = 1'b0;
            end
            if (e_draw && open_n) begin
                k_sat = (k_d == 16'hFFFF) ? k_d : k_d + 16'd1;
                p1_d  = e_vert;
                if (k_d == '0) p0_d = e_vert;
                case (type_d)
                    4'd0: begin
                        emit = 1'b1;
                        a_v  = e_vert;
                        k_d  = k_sat;
                    end
                    4'd1: begin
                        if (k_d != '0) begin
                            emit   = 1'b1;
                            kind_n = 2'd1;
                            a_v    = p1_q;
                            b_v    = e_vert;
                            k_d    = '0;
                        end else begin
                            k_d = k_sat;
                        end
                    end
                    4'd2: begin
                        if (k_d != '0) begin
                            emit   = 1'b1;
                            kind_n = 2'd1;
                            a_v    = p1_q;
                            b_v    = e_vert;
                        end
                        k_d = k_sat;
                    end
                    4'd3: begin
                        if (k_d == 16'd2) begin
                            is_tri = 1'b1;
                            a_v    = p0_q;
                            b_v    = p1_q;
                            c_v    = e_vert;
                            k_d    = '0;
                        end else begin
                            k_d = k_sat;
                        end
                    end
                    4'd4: begin
                        // p0/p1 slide as the two most recent vertices of the strip.
                        if (k_d != '0) p0_d = p1_q;
                        if (k_d >= 16'd2) begin
                            is_tri = 1'b1;
                            a_v    = par_d ? p1_q : p0_q;
                            b_v    = par_d ? p0_q : p1_q;
                            c_v    = e_vert;
                            par_d  = !par_d;
                        end
                        k_d = k_sat;
                    end
                    4'd5: begin
                        if (k_d >= 16'd2) begin
                            is_tri = 1'b1;
                            a_v    = p0_q;
                            b_v    = p1_q;
                            c_v    = e_vert;
                        end
                        k_d = k_sat;
                    end
                    default: ;
                endcase
            end
            if (is_tri) begin
                emit   = 1'b1;
                kind_n = 2'd2;
`ifdef PA_CULL_DEGENERATE_EN
                if (a_v == b_v || b_v == c_v || a_v == c_v) emit = 1'b0;
`endif
            end
            if (e_end) begin
                open_n = 1'b0;
                k_d    = '0;
            end
            if (emit) begin
                state_d = StEmit;
                close_d = !open_n;
                kind_d  = kind_n;
                v0_d    = a_v;
                v1_d    = b_v;
                v2_d    = c_v;
            end else begin
                state_d = open_n ? StAccum : StIdle;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            close_q <= 1'b0;
            type_q  <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            k_q     <= '0;
            par_q   <= 1'b0;
            kind_q  <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
        end else begin
            state_q <= state_d;
            close_q <= close_d;
            type_q  <= type_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            k_q     <= k_d;
            par_q   <= par_d;
            kind_q  <= kind_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
        end
    end

    assign PrimValid = (state_q == StEmit);
    assign PrimKind  = kind_q;
    assign V0        = v0_q;
    assign V1        = v1_q;
    assign V2        = v2_q;
    assign Overflow  = overflow_q;
    assign Busy      = !fifo_empty || PrimValid;

endmodule

// File: tb/tb_prim_assembler.sv
`timescale 1ns/1ps
// Bench for prim_assembler: directed scenarios with literal expectations, then random event
// streams checked against a list-based primitive model.
module tb_prim_assembler;

    logic        CLOCK_50 = 1'b0;
    logic        Reset = 1'b0;
    logic        StartPrimitive = 1'b0;
    logic [3:0]  PrimitiveType = 4'd0;
    logic        Draw = 1'b0;
    logic [31:0] Vertex = 32'd0;
    logic        EndPrimitive = 1'b0;
    logic        PrimReady = 1'b1;
    logic        PrimValid;
    logic [1:0]  PrimKind;
    logic [31:0] V0, V1, V2;
    logic        Overflow;
    logic        Busy;

    prim_assembler #(.FIFO_DEPTH(8), .FIFO_AW(3), .VW(32)) dut (
        .CLOCK_50(CLOCK_50), .Reset(Reset), .StartPrimitive(StartPrimitive),
        .PrimitiveType(PrimitiveType), .Draw(Draw), .Vertex(Vertex), .EndPrimitive(EndPrimitive),
        .PrimReady(PrimReady), .PrimValid(PrimValid), .PrimKind(PrimKind), .V0(V0), .V1(V1),
        .V2(V2), .Overflow(Overflow), .Busy(Busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } prim_t;

    int    checks = 0;
    int    errors = 0;
    prim_t got[$];
    prim_t exp_q[$];
    prim_t last_out;
    logic  last_stall = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_got(input string tag, input int idx, input prim_t expv);
        logic [127:0] obs;
        obs = (idx < got.size()) ? {30'd0, got[idx]} : '1;
        chk(tag, obs, {30'd0, expv});
    endtask

    // Capture accepted primitives; outputs must not move while stalled.
    always @(negedge CLOCK_50) begin
        if (Reset && last_stall && PrimValid) begin
            checks++;
            assert ({PrimKind, V0, V1, V2} === last_out) else begin
                errors++;
                $error("FAIL hold observed %h expected %h", {PrimKind, V0, V1, V2}, last_out);
            end
        end
        if (Reset && PrimValid && PrimReady) got.push_back({PrimKind, V0, V1, V2});
        last_out   <= {PrimKind, V0, V1, V2};
        last_stall <= Reset && PrimValid && !PrimReady;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference model: vertices of the open primitive kept as a list.
    logic        m_open = 1'b0;
    logic [3:0]  m_type = 4'd0;
    logic [31:0] m_v[$];

    function automatic void add_tri(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] c);
`ifdef PA_CULL_DEGENERATE_EN
        if (a == b || b == c || a == c) return;
`endif
        exp_q.push_back({2'd2, a, b, c});
    endfunction

    function automatic void model(input logic s, input logic [3:0] t, input logic d,
                                  input logic [31:0] v, input logic e);
        int n;
        if (s) begin
            m_open = 1'b1;
            m_type = t;
            m_v.delete();
        end
        if (d && m_open) begin
            m_v.push_back(v);
            n = m_v.size();
            case (m_type)
                4'd0: begin exp_q.push_back({2'd0, v, 32'd0, 32'd0}); m_v.delete(); end
                4'd1: if (n == 2) begin
                    exp_q.push_back({2'd1, m_v[0], m_v[1], 32'd0});
                    m_v.delete();
                end
                4'd2: if (n >= 2) exp_q.push_back({2'd1, m_v[n-2], m_v[n-1], 32'd0});
                4'd3: if (n == 3) begin add_tri(m_v[0], m_v[1], m_v[2]); m_v.delete(); end
                4'd4: if (n >= 3) begin
                    if (((n - 3) % 2) == 0) add_tri(m_v[n-3], m_v[n-2], m_v[n-1]);
                    else add_tri(m_v[n-2], m_v[n-3], m_v[n-1]);
                end
                4'd5: if (n >= 3) add_tri(m_v[0], m_v[n-2], m_v[n-1]);
                default: ;
            endcase
        end
        if (e) begin
            m_open = 1'b0;
            m_v.delete();
        end
    endfunction

    task automatic send(input logic s, input logic [3:0] t, input logic d, input logic [31:0] v,
                        input logic e);
        StartPrimitive = s;
        PrimitiveType  = t;
        Draw           = d;
        Vertex         = v;
        EndPrimitive   = e;
        @(posedge CLOCK_50);
        #1;
        StartPrimitive = 1'b0;
        Draw           = 1'b0;
        EndPrimitive   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    logic        rdy_prev_low = 1'b0;
    task automatic set_rdy();
        if (rdy_prev_low) PrimReady = 1'b1;
        else PrimReady = ($urandom % 3) != 0;
        rdy_prev_low = !PrimReady;
    endtask

    logic [31:0] va[5];
    logic [31:0] prev_v;
    logic        rs, rd, re;
    logic [3:0]  rt;
    logic [31:0] rv;

    initial begin
        va = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D, 32'hE000_000E};

        // Reset state
        idle(2);
        chk("rst_valid", PrimValid, 1'b0);
        chk("rst_kind", PrimKind, 2'd0);
        chk("rst_v", {V0, V1, V2}, 96'd0);
        chk("rst_ovf", Overflow, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        Reset = 1'b1;
        idle(1);

        // Triangles with latency check
        send(1, 4'd3, 0, 0, 0);
        send(0, 0, 1, va[0], 0);
        send(0, 0, 1, va[1], 0);
        send(0, 0, 1, va[2], 0);
        chk("tri_lat_early", PrimValid, 1'b0);
        send(0, 0, 0, 0, 1);
        chk("tri_lat_valid", PrimValid, 1'b1);
        chk("tri_out", {PrimKind, V0, V1, V2}, {2'd2, va[0], va[1], va[2]});
        idle(1);
        chk("tri_done_valid", PrimValid, 1'b0);
        chk("tri_done_busy", Busy, 1'b0);
        chk("tri_count", got.size(), 1);
        got.delete();

        // Triangle strip then fan over the same vertices
        send(1, 4'd4, 0, 0, 0);
        for (int i = 0; i < 5; i++) send(0, 0, 1, va[i], 0);
        send(0, 0, 0, 0, 1);
        idle(4);
        chk("strip_count", got.size(), 3);
        chk_got("strip0", 0, {2'd2, va[0], va[1], va[2]});
        chk_got("strip1", 1, {2'd2, va[2], va[1], va[3]});
        chk_got("strip2", 2, {2'd2, va[2], va[3], va[4]});
        got.delete();
        send(1, 4'd5, 0, 0, 0);
        for (int i = 0; i < 5; i++) send(0, 0, 1, va[i], 0);
        send(0, 0, 0, 0, 1);
        idle(4);
        chk("fan_count", got.size(), 3);
        chk_got("fan0", 0, {2'd2, va[0], va[1], va[2]});
        chk_got("fan1", 1, {2'd2, va[0], va[2], va[3]});
        chk_got("fan2", 2, {2'd2, va[0], va[3], va[4]});
        got.delete();

        // Lines: trailing odd vertex discarded
        send(1, 4'd1, 0, 0, 0);
        for (int i = 0; i < 3; i++) send(0, 0, 1, va[i], 0);
        send(0, 0, 0, 0, 1);
        idle(4);
        chk("lines_count", got.size(), 1);
        chk_got("lines0", 0, {2'd1, va[0], va[1], 32'd0});
        chk("lines_busy", Busy, 1'b0);
        got.delete();

        // Degenerate triangle
        send(1, 4'd3, 0, 0, 0);
        send(0, 0, 1, va[0], 0);
        send(0, 0, 1, va[0], 0);
        for (int i = 1; i < 5; i++) send(0, 0, 1, va[i], 0);
        send(0, 0, 0, 0, 1);
        idle(4);
`ifdef PA_CULL_DEGENERATE_EN
        chk("cull_count", got.size(), 1);
        chk_got("cull0", 0, {2'd2, va[2], va[3], va[4]});
`else
        chk("cull_count", got.size(), 2);
        chk_got("cull0", 0, {2'd2, va[0], va[0], va[1]});
        chk_got("cull1", 1, {2'd2, va[2], va[3], va[4]});
`endif
        got.delete();

        // Overflow under back-pressure
        PrimReady = 1'b0;
        send(1, 4'd0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 10; i++) send(0, 0, 1, 32'd101 + 32'(i), 0);
        idle(8);
        chk("ovf_flag", Overflow, 1'b1);
        chk("ovf_held", {PrimValid, PrimKind, V0}, {1'b1, 2'd0, 32'd101});
        chk("ovf_busy", Busy, 1'b1);
        PrimReady = 1'b1;
        idle(15);
        chk("ovf_count", got.size(), 9);
        for (int i = 0; i < 9; i++)
            chk_got("ovf_pt", i, {2'd0, 32'd101 + 32'(i), 32'd0, 32'd0});
        chk("ovf_sticky", Overflow, 1'b1);
        got.delete();

        // Asynchronous reset mid-handshake
        PrimReady = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 0, 1, 32'd201 + 32'(i), 0);
        idle(2);
        chk("rstmid_pre", {PrimValid, V0}, {1'b1, 32'd201});
        #2;
        Reset = 1'b0;
        #1;
        chk("rstmid_valid", PrimValid, 1'b0);
        chk("rstmid_out", {PrimKind, V0, V1, V2}, 98'd0);
        chk("rstmid_busy", Busy, 1'b0);
        chk("rstmid_ovf", Overflow, 1'b0);
        @(posedge CLOCK_50);
        #1;
        Reset = 1'b1;
        PrimReady = 1'b1;
        idle(3);
        chk("rstmid_after_busy", Busy, 1'b0);
        chk("rstmid_after_count", got.size(), 0);
        // Draw with no open primitive is dropped
        send(0, 0, 1, 32'h5555, 0);
        idle(3);
        chk("idle_draw_count", got.size(), 0);
        got.delete();

        // Random streams; ready never low two cycles running so the FIFO cannot fill
        prev_v = 32'h1234;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom % 100) < 8;
            re = ($urandom % 100) < 8;
            rd = ($urandom % 100) < 85;
            if (!(rs || rd || re)) rd = 1'b1;
            rt = 4'($urandom % 8);
            rv = (($urandom % 6) == 0) ? prev_v : $urandom;
            prev_v = rv;
            set_rdy();
            model(rs, rt, rd, rv, re);
            send(rs, rt, rd, rv, re);
            repeat (1 + ($urandom % 3)) begin
                set_rdy();
                idle(1);
            end
        end
        PrimReady = 1'b1;
        idle(20);
        chk("rand_ovf", Overflow, 1'b0);
        chk("rand_busy", Busy, 1'b0);
        chk("rand_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) chk_got("rand_prim", i, exp_q[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
